// File: rtl/uart_echo_responder.sv
// ============================================================================
// Module   : uart_echo_responder
// Purpose  : Buffers UART rx bytes in a small FIFO and re-transmits them, with
//            optional lowercase->uppercase mapping and CR -> CR,LF expansion.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_echo_responder #(
    parameter int DEPTH     = 4,
    parameter bit ECHO_CRLF = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             upcase,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [CNT_W-1:0] echo_count,
    output logic             busy
);

    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [7:0]   C_CR    = 8'h0D;
    localparam logic [7:0]   C_LF    = 8'h0A;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_SEND_LF = 2'd2
    } state_t;

    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_occ;
    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_tx_data;
    logic [7:0]       r_last_byte;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic             w_load_lf;
    logic             w_done;
    logic [7:0]       w_head;
    logic [7:0]       w_xform;

    assign w_full   = (r_occ == C_DEPTH);
    assign w_empty  = (r_occ == '0);
    assign rx_ready = rst_n && enable && !w_full;
    assign w_push   = rx_valid && rx_ready;
    assign w_head   = r_mem[r_rptr];
    assign w_xform  = (upcase && (w_head >= 8'h61) && (w_head <= 8'h7A)) ? (w_head - 8'h20) : w_head;

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + (AW+1)'(1);
                2'b01:   r_occ <= r_occ - (AW+1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_load    = 1'b0;
        w_load_lf = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_load = 1'b1;
                    w_next = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    w_done = 1'b1;
                    // CR detection looks at the raw byte, never the mapped one.
                    if (ECHO_CRLF && (r_last_byte == C_CR)) begin
                        w_load_lf = 1'b1;
                        w_next    = S_SEND_LF;
                    end else if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_load = 1'b1;
                        w_next = S_SEND;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_SEND_LF: begin
                if (tx_ready) begin
                    w_done = 1'b1;
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_load = 1'b1;
                        w_next = S_SEND;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tx_data   <= 8'h00;
            r_last_byte <= 8'h00;
            r_count     <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_tx_data   <= w_xform;
                r_last_byte <= w_head;
            end else if (w_load_lf) begin
                r_tx_data <= C_LF;
            end
            if (w_done) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_valid   = (r_state != S_IDLE);
    assign echo_count = r_count;
    assign busy       = !w_empty || tx_valid;

endmodule

`default_nettype wire

// File: tb/tb_uart_echo_responder.sv
// ============================================================================
// Module   : tb_uart_echo_responder
// Purpose  : Scenario bench for uart_echo_responder (CRLF and non-CRLF builds)
//            checked against a queue-based reference of the echo rules.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_echo_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        upcase;
    logic [7:0]  rx_data;
    logic        rx_valid_a, rx_valid_b;
    logic        tx_ready_a, tx_ready_b;
    logic        rx_ready_a, rx_ready_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic        tx_valid_a, tx_valid_b;
    logic [15:0] echo_count_a, echo_count_b;
    logic        busy_a, busy_b;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    uart_echo_responder #(.DEPTH(4), .ECHO_CRLF(1'b1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .upcase(upcase),
        .rx_data(rx_data), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .echo_count(echo_count_a), .busy(busy_a)
    );

    uart_echo_responder #(.DEPTH(4), .ECHO_CRLF(1'b0), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .upcase(upcase),
        .rx_data(rx_data), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .echo_count(echo_count_b), .busy(busy_b)
    );

    // Reference model: every accepted byte yields its mapped form, plus LF after CR
    // on the CRLF build. Observed tx handshakes are collected for comparison.
    logic [7:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
    int         got_cyc[$];
    int         cyc = 0;
    int         tx_hs_a = 0;
    bit         store = 1'b1;

    function automatic logic [7:0] xf(input logic [7:0] b);
        if (upcase && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
        return b;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_a.delete(); exp_b.delete(); got_a.delete(); got_b.delete(); got_cyc.delete();
        end else begin
            if (rx_valid_a && rx_ready_a && store) begin
                exp_a.push_back(xf(rx_data));
                if (rx_data == 8'h0D) exp_a.push_back(8'h0A);
            end
            if (rx_valid_b && rx_ready_b && store) exp_b.push_back(xf(rx_data));
            if (tx_valid_a && tx_ready_a) begin
                tx_hs_a++;
                if (store) begin
                    got_a.push_back(tx_data_a);
                    got_cyc.push_back(cyc);
                end
            end
            if (tx_valid_b && tx_ready_b && store) got_b.push_back(tx_data_b);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_q();
        exp_a.delete(); exp_b.delete(); got_a.delete(); got_b.delete(); got_cyc.delete();
    endtask

    task automatic send(input logic [7:0] b, input bit to_b, input bit rnd);
        bit ok = 1'b0;
        rx_data = b;
        if (to_b) rx_valid_b = 1'b1; else rx_valid_a = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = to_b ? rx_ready_b : rx_ready_a;
            tick();
            if (rnd) begin
                tx_ready_a = 1'($urandom_range(0, 1));
                tx_ready_b = 1'($urandom_range(0, 1));
            end
        end
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
        if (!ok) begin
            checks++;
            $display("FAIL send_timeout byte=%h accepted=0 want=1", b);
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        tx_ready_a = 1'b1;
        tx_ready_b = 1'b1;
        for (int n = 0; n < 500 && !done; n++) begin
            @(negedge clk);
            done = !busy_a && !busy_b;
        end
        tick();
        if (!done) begin
            checks++;
            $display("FAIL drain_timeout busy_a=%b busy_b=%b want=0", busy_a, busy_b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; upcase = 1'b0; rx_data = 8'h00;
        rx_valid_a = 1'b0; rx_valid_b = 1'b0; tx_ready_a = 1'b0; tx_ready_b = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({tx_valid_a, tx_data_a, busy_a, rx_ready_a} !== 11'h0) $display("FAIL reset_outputs got v=%b d=%h busy=%b rdy=%b want all 0", tx_valid_a, tx_data_a, busy_a, rx_ready_a);
        else passed++;
        checks++;
        if (echo_count_a !== 16'h0) $display("FAIL reset_count got=%h want=0000", echo_count_a);
        else passed++;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rx_ready_a !== 1'b1) $display("FAIL reset_release_rx_ready got=%b want=1", rx_ready_a);
        else passed++;
        tick();
    endtask

    task automatic test_latency();
        tx_ready_a = 1'b0;
        clear_q();
        send(8'h7A, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (tx_valid_a !== 1'b0 || busy_a !== 1'b1) $display("FAIL latency_edgeE got v=%b busy=%b want v=0 busy=1", tx_valid_a, busy_a);
        else passed++;
        tick();
        @(negedge clk);
        checks++;
        if (tx_valid_a !== 1'b1 || tx_data_a !== 8'h7A) $display("FAIL latency_edgeE1 got v=%b d=%h want v=1 d=7a", tx_valid_a, tx_data_a);
        else passed++;
        tick();
        tx_ready_a = 1'b1;
        tick();
        tx_ready_a = 1'b0;
        @(negedge clk);
        checks++;
        if (echo_count_a !== 16'd1 || busy_a !== 1'b0 || tx_valid_a !== 1'b0) $display("FAIL first_echo got cnt=%0d busy=%b v=%b want cnt=1 busy=0 v=0", echo_count_a, busy_a, tx_valid_a);
        else passed++;
        tick();
    endtask

    task automatic test_upcase();
        logic [7:0]  want[3] = '{8'h5A, 8'h41, 8'h31};
        logic [7:0]  in[3]   = '{8'h7A, 8'h41, 8'h31};
        logic [15:0] c0;
        int          bad = 0;
        upcase = 1'b1; tx_ready_a = 1'b1;
        clear_q();
        c0 = echo_count_a;
        for (int i = 0; i < 3; i++) send(in[i], 1'b0, 1'b0);
        drain();
        for (int i = 0; i < 3; i++) if (got_a.size() <= i || got_a[i] !== want[i]) bad++;
        checks++;
        if (bad != 0 || got_a.size() != 3) $display("FAIL upcase_seq got size=%0d bad=%0d want size=3 bad=0 (5a 41 31)", got_a.size(), bad);
        else passed++;
        checks++;
        if (16'(echo_count_a - c0) !== 16'd3) $display("FAIL upcase_count got=%0d want=3", 16'(echo_count_a - c0));
        else passed++;
        upcase = 1'b0;
    endtask

    task automatic test_crlf();
        logic [7:0]  in[3]    = '{8'h68, 8'h0D, 8'h69};
        logic [7:0]  want_a[4] = '{8'h68, 8'h0D, 8'h0A, 8'h69};
        logic [7:0]  want_b[3] = '{8'h68, 8'h0D, 8'h69};
        logic [15:0] ca, cb;
        int          bad_a = 0, bad_b = 0;
        clear_q();
        ca = echo_count_a; cb = echo_count_b;
        tx_ready_a = 1'b1; tx_ready_b = 1'b1;
        for (int i = 0; i < 3; i++) send(in[i], 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send(in[i], 1'b1, 1'b0);
        drain();
        for (int i = 0; i < 4; i++) if (got_a.size() <= i || got_a[i] !== want_a[i]) bad_a++;
        for (int i = 0; i < 3; i++) if (got_b.size() <= i || got_b[i] !== want_b[i]) bad_b++;
        checks++;
        if (bad_a != 0 || got_a.size() != 4) $display("FAIL crlf_on_seq got size=%0d bad=%0d want size=4 bad=0", got_a.size(), bad_a);
        else passed++;
        checks++;
        if (16'(echo_count_a - ca) !== 16'd4) $display("FAIL crlf_on_count got=%0d want=4", 16'(echo_count_a - ca));
        else passed++;
        checks++;
        if (bad_b != 0 || got_b.size() != 3) $display("FAIL crlf_off_seq got size=%0d bad=%0d want size=3 bad=0", got_b.size(), bad_b);
        else passed++;
        checks++;
        if (16'(echo_count_b - cb) !== 16'd3) $display("FAIL crlf_off_count got=%0d want=3", 16'(echo_count_b - cb));
        else passed++;
    endtask

    task automatic test_back_to_back();
        int accepted = 0;
        int bad = 0;
        tx_ready_a = 1'b0;
        clear_q();
        rx_valid_a = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            bit ok = 1'b0;
            rx_data = 8'(i);
            for (int n = 0; n < 8 && !ok; n++) begin
                @(negedge clk);
                ok = rx_ready_a;
                tick();
            end
            if (ok) accepted++;
        end
        @(negedge clk);
        checks++;
        if (accepted != 5) $display("FAIL full_accept_count got=%0d want=5", accepted);
        else passed++;
        checks++;
        if (rx_ready_a !== 1'b0) $display("FAIL full_rx_ready got=%b want=0", rx_ready_a);
        else passed++;
        tick();
        rx_valid_a = 1'b0;
        tx_ready_a = 1'b1;
        send(8'h06, 1'b0, 1'b0);
        drain();
        for (int i = 0; i < 6; i++) if (got_a.size() <= i || got_a[i] !== 8'(i + 1)) bad++;
        checks++;
        if (bad != 0 || got_a.size() != 6) $display("FAIL b2b_seq got size=%0d bad=%0d want size=6 bad=0", got_a.size(), bad);
        else passed++;
        bad = 0;
        for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] - got_cyc[i-1] != 1) bad++;
        checks++;
        if (bad != 0 || got_cyc.size() != 6) $display("FAIL b2b_bubbles got gaps=%0d hs=%0d want gaps=0 hs=6", bad, got_cyc.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        tx_ready_a = 1'b0;
        clear_q();
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_ready_a !== 1'b0) $display("FAIL midreset_rx_ready got=%b want=0", rx_ready_a);
        else passed++;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_valid_a !== 1'b0 || busy_a !== 1'b0 || echo_count_a !== 16'h0 || tx_data_a !== 8'h00)
            $display("FAIL midreset_state got v=%b busy=%b cnt=%0d d=%h want 0 0 0 00", tx_valid_a, busy_a, echo_count_a, tx_data_a);
        else passed++;
        tick();
        tx_ready_a = 1'b1;
        send(8'h55, 1'b0, 1'b0);
        drain();
        checks++;
        if (got_a.size() != 1 || got_a[0] !== 8'h55 || echo_count_a !== 16'd1)
            $display("FAIL midreset_fresh got size=%0d cnt=%0d want size=1 byte=55 cnt=1", got_a.size(), echo_count_a);
        else passed++;
    endtask

    task automatic test_enable_drain();
        int bad = 0;
        tx_ready_a = 1'b0;
        clear_q();
        send(8'h21, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        enable = 1'b0;
        rx_data = 8'h99;
        rx_valid_a = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (rx_ready_a !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) $display("FAIL disable_rx_ready got high_cycles=%0d want=0", bad);
        else passed++;
        drain();
        checks++;
        if (got_a.size() != 2 || got_a[0] !== 8'h21 || got_a[1] !== 8'h22 || busy_a !== 1'b0)
            $display("FAIL disable_drain got size=%0d busy=%b want size=2 (21 22) busy=0", got_a.size(), busy_a);
        else passed++;
        rx_valid_a = 1'b0;
        enable = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        int acc = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        store = 1'b0;
        tx_hs_a = 0;
        tx_ready_a = 1'b1;
        rx_data = 8'h41;
        rx_valid_a = 1'b1;
        for (int n = 0; n < 70000 && acc < 65535; n++) begin
            @(negedge clk);
            if (rx_ready_a) acc++;
            tick();
            if (acc == 65535) rx_valid_a = 1'b0;
        end
        rx_valid_a = 1'b0;
        drain();
        checks++;
        if (echo_count_a !== 16'hFFFF || tx_hs_a != 65535) $display("FAIL wrap_pre got cnt=%h hs=%0d want cnt=ffff hs=65535", echo_count_a, tx_hs_a);
        else passed++;
        store = 1'b1;
        send(8'h41, 1'b0, 1'b0);
        drain();
        checks++;
        if (echo_count_a !== 16'h0000) $display("FAIL wrap_zero got=%h want=0000", echo_count_a);
        else passed++;
    endtask

    task automatic test_random();
        for (int batch = 0; batch < 4; batch++) begin
            bit          to_b = batch[0];
            logic [15:0] c0;
            int          bad = 0;
            logic [7:0]  edge_vals[4] = '{8'h60, 8'h61, 8'h7A, 8'h7B};
            upcase = 1'($urandom_range(0, 1));
            clear_q();
            c0 = to_b ? echo_count_b : echo_count_a;
            for (int k = 0; k < 25; k++) begin
                logic [7:0] b;
                case ($urandom_range(0, 3))
                    0:       b = 8'h0D;
                    1:       b = 8'(8'h61 + $urandom_range(0, 25));
                    2:       b = 8'($urandom_range(0, 255));
                    default: b = edge_vals[$urandom_range(0, 3)];
                endcase
                send(b, to_b, 1'b1);
            end
            drain();
            if (to_b) begin
                for (int i = 0; i < exp_b.size(); i++) if (got_b.size() <= i || got_b[i] !== exp_b[i]) bad++;
                checks++;
                if (bad != 0 || got_b.size() != exp_b.size()) $display("FAIL random_b%0d_seq got size=%0d bad=%0d want size=%0d bad=0", batch, got_b.size(), bad, exp_b.size());
                else passed++;
                checks++;
                if (16'(echo_count_b - c0) !== 16'(exp_b.size())) $display("FAIL random_b%0d_count got=%0d want=%0d", batch, 16'(echo_count_b - c0), exp_b.size());
                else passed++;
            end else begin
                for (int i = 0; i < exp_a.size(); i++) if (got_a.size() <= i || got_a[i] !== exp_a[i]) bad++;
                checks++;
                if (bad != 0 || got_a.size() != exp_a.size()) $display("FAIL random_a%0d_seq got size=%0d bad=%0d want size=%0d bad=0", batch, got_a.size(), bad, exp_a.size());
                else passed++;
                checks++;
                if (16'(echo_count_a - c0) !== 16'(exp_a.size())) $display("FAIL random_a%0d_count got=%0d want=%0d", batch, 16'(echo_count_a - c0), exp_a.size());
                else passed++;
            end
        end
        upcase = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_upcase();
        test_crlf();
        test_back_to_back();
        test_reset_mid();
        test_enable_drain();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
